// File: rtl/scr1_dm_pkg.sv
// scr1_dm_pkg: Debug Module register map, abstract-command FSM states,
// cmderr codes and register field positions.
package scr1_dm_pkg;

  typedef enum logic [6:0] {
    DM_DATA0      = 7'h04,
    DM_DATA1      = 7'h05,
    DM_DMCONTROL  = 7'h10,
    DM_DMSTATUS   = 7'h11,
    DM_ABSTRACTCS = 7'h16,
    DM_COMMAND    = 7'h17,
    DM_PROGBUF0   = 7'h20,
    DM_PROGBUF1   = 7'h21
  } dm_addr_e;

  typedef enum logic {ABS_IDLE = 1'b0, ABS_REQ = 1'b1} abs_state_e;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXC        = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  localparam int DMCONTROL_HALTREQ   = 31;
  localparam int DMCONTROL_RESUMEREQ = 30;
  localparam int DMCONTROL_NDMRESET  = 1;
  localparam int DMCONTROL_DMACTIVE  = 0;

  localparam int DMSTATUS_ALLRESUMEACK  = 17;
  localparam int DMSTATUS_ANYRESUMEACK  = 16;
  localparam int DMSTATUS_ALLRUNNING    = 11;
  localparam int DMSTATUS_ANYRUNNING    = 10;
  localparam int DMSTATUS_ALLHALTED     = 9;
  localparam int DMSTATUS_ANYHALTED     = 8;
  localparam int DMSTATUS_AUTHENTICATED = 7;
  localparam int DMSTATUS_VERSION_LO    = 0;

  localparam int ABSTRACTCS_PROGBUFSIZE_LO = 24;
  localparam int ABSTRACTCS_BUSY           = 12;
  localparam int ABSTRACTCS_CMDERR_LO      = 8;
  localparam int ABSTRACTCS_DATACOUNT_LO   = 0;

  localparam logic [3:0] DM_DATACOUNT = 4'd2;

endpackage

// File: rtl/scr1_dm_abs_cmd_fsm.sv
// scr1_dm_abs_cmd_fsm: abstract command latch, busy/cmderr tracking and
// the request/ack handshake toward the hart.
module scr1_dm_abs_cmd_fsm
  import scr1_dm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cmd_wr,
  input  logic              data_wr,
  input  logic              cmderr_wr,
  input  logic [2:0]        cmderr_w1c,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              halted,
  input  logic              ack,
  input  logic [2:0]        err,
  output logic              busy,
  output logic              cmd_req,
  output logic [2:0]        cmderr,
  output logic [DATA_W-1:0] cmd
);

  abs_state_e        state, state_d;
  logic [2:0]        cmderr_d;
  logic [DATA_W-1:0] cmd_d;
  logic              no_err;

  assign busy    = state == ABS_REQ;
  assign cmd_req = busy;
  assign no_err  = cmderr == CMDERR_NONE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ABS_IDLE;
      cmderr <= CMDERR_NONE;
      cmd    <= '0;
    end else begin
      state  <= state_d;
      cmderr <= cmderr_d;
      cmd    <= cmd_d;
    end

  // later assignments take priority: an error ack beats a same-cycle W1C
  always_comb begin
    state_d  = state;
    cmderr_d = cmderr_wr ? cmderr & ~cmderr_w1c : cmderr;
    cmd_d    = cmd;
    if ((cmd_wr | data_wr) & busy & no_err) cmderr_d = CMDERR_BUSY;
    if (cmd_wr & ~busy & no_err) begin
      if (halted) begin
        state_d = ABS_REQ;
        cmd_d   = cmd_wdata;
      end else cmderr_d = CMDERR_HALTRESUME;
    end
    if (busy & ack) begin
      state_d = ABS_IDLE;
      if (err != CMDERR_NONE) cmderr_d = err;
    end
    if (clr) begin
      state_d  = ABS_IDLE;
      cmderr_d = CMDERR_NONE;
      cmd_d    = '0;
    end
  end

endmodule

// File: rtl/scr1_dm_dmi_target.sv
// scr1_dm_dmi_target: DMI responder holding the DM register subset.
// Define SCR1_DMI_TARGET_PROGBUF_EN to add progbuf0/1 at 0x20/0x21.
module scr1_dm_dmi_target
  import scr1_dm_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         ADDR_W     = 7,
  parameter logic [3:0] DM_VERSION = 4'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmi2dm_req_i,
  input  logic              dmi2dm_wr_i,
  input  logic [ADDR_W-1:0] dmi2dm_addr_i,
  input  logic [DATA_W-1:0] dmi2dm_wdata_i,
  output logic              dm2dmi_resp_o,
  output logic [DATA_W-1:0] dm2dmi_rdata_o,
  output logic              dm2hart_haltreq_o,
  output logic              dm2hart_resumereq_o,
  input  logic              hart2dm_resumeack_i,
  input  logic              hart2dm_halted_i,
  output logic              dm2hart_cmd_req_o,
  output logic [DATA_W-1:0] dm2hart_cmd_o,
  input  logic              hart2dm_cmd_ack_i,
  input  logic [2:0]        hart2dm_cmd_err_i,
  input  logic              hart2dm_data0_we_i,
  input  logic [DATA_W-1:0] hart2dm_data0_i,
`ifdef SCR1_DMI_TARGET_PROGBUF_EN
  output logic [DATA_W-1:0] dm2hart_progbuf0_o,
  output logic [DATA_W-1:0] dm2hart_progbuf1_o,
`endif
  output logic              dm_ndmreset_o,
  output logic              dm_dmactive_o
);

  logic [DATA_W-1:0] data0, data1, ctl_rd, status_rd, abscs_rd, rdata;
  logic              haltreq, ndmreset, dmactive, resume_pend, resumeack;
  logic              wr, act_wr, dmactive_d, clr, busy;
  logic              sel_d0, sel_d1, sel_ctl, sel_st, sel_acs, sel_cmd, sel_data;
  logic [2:0]        cmderr;

  assign sel_d0  = dmi2dm_addr_i == ADDR_W'(DM_DATA0);
  assign sel_d1  = dmi2dm_addr_i == ADDR_W'(DM_DATA1);
  assign sel_ctl = dmi2dm_addr_i == ADDR_W'(DM_DMCONTROL);
  assign sel_st  = dmi2dm_addr_i == ADDR_W'(DM_DMSTATUS);
  assign sel_acs = dmi2dm_addr_i == ADDR_W'(DM_ABSTRACTCS);
  assign sel_cmd = dmi2dm_addr_i == ADDR_W'(DM_COMMAND);

`ifdef SCR1_DMI_TARGET_PROGBUF_EN
  localparam logic [4:0] PROGBUFSIZE = 5'd2;
  logic sel_pb0, sel_pb1;
  assign sel_pb0  = dmi2dm_addr_i == ADDR_W'(DM_PROGBUF0);
  assign sel_pb1  = dmi2dm_addr_i == ADDR_W'(DM_PROGBUF1);
  assign sel_data = sel_d0 | sel_d1 | sel_pb0 | sel_pb1;
`else
  localparam logic [4:0] PROGBUFSIZE = 5'd0;
  assign sel_data = sel_d0 | sel_d1;
`endif

  // clearing dmactive resets the DM in the same cycle as the write, so the
  // FSM drops its request on the very next cycle
  assign wr         = dmi2dm_req_i & dmi2dm_wr_i;
  assign dmactive_d = (wr & sel_ctl) ? dmi2dm_wdata_i[DMCONTROL_DMACTIVE] : dmactive;
  assign clr        = ~dmactive_d;
  assign act_wr     = wr & dmactive;

  scr1_dm_abs_cmd_fsm #(.DATA_W(DATA_W)) i_abs_cmd_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cmd_wr    (act_wr & sel_cmd),
    .data_wr   (act_wr & sel_data),
    .cmderr_wr (act_wr & sel_acs),
    .cmderr_w1c(dmi2dm_wdata_i[ABSTRACTCS_CMDERR_LO +: 3]),
    .cmd_wdata (dmi2dm_wdata_i),
    .halted    (hart2dm_halted_i),
    .ack       (hart2dm_cmd_ack_i),
    .err       (hart2dm_cmd_err_i),
    .busy      (busy),
    .cmd_req   (dm2hart_cmd_req_o),
    .cmderr    (cmderr),
    .cmd       (dm2hart_cmd_o)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dmactive <= 1'b0;
    else dmactive <= dmactive_d;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data0       <= '0;
      data1       <= '0;
      haltreq     <= 1'b0;
      ndmreset    <= 1'b0;
      resume_pend <= 1'b0;
      resumeack   <= 1'b0;
    end else if (clr) begin
      data0       <= '0;
      data1       <= '0;
      haltreq     <= 1'b0;
      ndmreset    <= 1'b0;
      resume_pend <= 1'b0;
      resumeack   <= 1'b0;
    end else begin
      if (act_wr & sel_d0 & ~busy) data0 <= dmi2dm_wdata_i;
      else if (busy & hart2dm_data0_we_i) data0 <= hart2dm_data0_i;
      if (act_wr & sel_d1 & ~busy) data1 <= dmi2dm_wdata_i;
      if (act_wr & sel_ctl) begin
        haltreq  <= dmi2dm_wdata_i[DMCONTROL_HALTREQ];
        ndmreset <= dmi2dm_wdata_i[DMCONTROL_NDMRESET];
      end
      if (hart2dm_resumeack_i) begin
        resume_pend <= 1'b0;
        resumeack   <= 1'b1;
      end
      if (act_wr & sel_ctl & dmi2dm_wdata_i[DMCONTROL_RESUMEREQ] & ~dmi2dm_wdata_i[DMCONTROL_HALTREQ]) begin
        resume_pend <= 1'b1;
        resumeack   <= 1'b0;
      end
    end

`ifdef SCR1_DMI_TARGET_PROGBUF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dm2hart_progbuf0_o <= '0;
      dm2hart_progbuf1_o <= '0;
    end else if (clr) begin
      dm2hart_progbuf0_o <= '0;
      dm2hart_progbuf1_o <= '0;
    end else begin
      if (act_wr & sel_pb0 & ~busy) dm2hart_progbuf0_o <= dmi2dm_wdata_i;
      if (act_wr & sel_pb1 & ~busy) dm2hart_progbuf1_o <= dmi2dm_wdata_i;
    end
`endif

  always_comb begin
    ctl_rd                                         = '0;
    ctl_rd[DMCONTROL_HALTREQ]                      = haltreq;
    ctl_rd[DMCONTROL_NDMRESET]                     = ndmreset;
    ctl_rd[DMCONTROL_DMACTIVE]                     = dmactive;
    status_rd                                      = '0;
    status_rd[DMSTATUS_ALLRESUMEACK]               = resumeack;
    status_rd[DMSTATUS_ANYRESUMEACK]               = resumeack;
    status_rd[DMSTATUS_ALLRUNNING]                 = ~hart2dm_halted_i;
    status_rd[DMSTATUS_ANYRUNNING]                 = ~hart2dm_halted_i;
    status_rd[DMSTATUS_ALLHALTED]                  = hart2dm_halted_i;
    status_rd[DMSTATUS_ANYHALTED]                  = hart2dm_halted_i;
    status_rd[DMSTATUS_AUTHENTICATED]              = 1'b1;
    status_rd[DMSTATUS_VERSION_LO +: 4]            = DM_VERSION;
    abscs_rd                                       = '0;
    abscs_rd[ABSTRACTCS_PROGBUFSIZE_LO +: 5]       = PROGBUFSIZE;
    abscs_rd[ABSTRACTCS_BUSY]                      = busy;
    abscs_rd[ABSTRACTCS_CMDERR_LO +: 3]            = cmderr;
    abscs_rd[ABSTRACTCS_DATACOUNT_LO +: 4]         = DM_DATACOUNT;
    rdata = sel_d0 ? data0 : sel_d1 ? data1 : sel_ctl ? ctl_rd :
            sel_st ? status_rd : sel_acs ? abscs_rd : '0;
`ifdef SCR1_DMI_TARGET_PROGBUF_EN
    if (sel_pb0) rdata = dm2hart_progbuf0_o;
    if (sel_pb1) rdata = dm2hart_progbuf1_o;
`endif
  end

  assign dm2dmi_resp_o       = dmi2dm_req_i;
  assign dm2dmi_rdata_o      = dmi2dm_req_i ? rdata : '0;
  assign dm2hart_haltreq_o   = haltreq;
  assign dm2hart_resumereq_o = resume_pend;
  assign dm_ndmreset_o       = ndmreset;
  assign dm_dmactive_o       = dmactive;

endmodule

// File: tb/tb_scr1_dm_dmi_target.sv
// tb_scr1_dm_dmi_target: directed vector table for the DM register and
// handshake corners, then random traffic against a behavioural DM model.
module tb_scr1_dm_dmi_target;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, wr = 1'b0, halted = 1'b0, rack = 1'b0, ack = 1'b0, we = 1'b0;
  logic [6:0]  addr = '0;
  logic [2:0]  err = '0;
  logic [31:0] wdata = '0, wb = '0;
  logic        resp, haltreq, resumereq, cmd_req, ndmreset, dmactive;
  logic [31:0] rdata, cmd;
  int          checks = 0, fails = 0;

  always #5 clk = ~clk;

  scr1_dm_dmi_target dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .dmi2dm_req_i       (req),
    .dmi2dm_wr_i        (wr),
    .dmi2dm_addr_i      (addr),
    .dmi2dm_wdata_i     (wdata),
    .dm2dmi_resp_o      (resp),
    .dm2dmi_rdata_o     (rdata),
    .dm2hart_haltreq_o  (haltreq),
    .dm2hart_resumereq_o(resumereq),
    .hart2dm_resumeack_i(rack),
    .hart2dm_halted_i   (halted),
    .dm2hart_cmd_req_o  (cmd_req),
    .dm2hart_cmd_o      (cmd),
    .hart2dm_cmd_ack_i  (ack),
    .hart2dm_cmd_err_i  (err),
    .hart2dm_data0_we_i (we),
    .hart2dm_data0_i    (wb),
    .dm_ndmreset_o      (ndmreset),
    .dm_dmactive_o      (dmactive)
  );

  typedef struct {
    logic        req, wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        halted, rack, ack;
    logic [2:0]  err;
    logic        we;
    logic [31:0] wb, exp_rdata;
    logic [5:0]  exp_flags;
    logic [31:0] exp_cmd;
  } vec_t;

  // behavioural DM state: what each register holds after every clock edge
  logic [31:0] m_data[2];
  logic        m_halt, m_ndm, m_act, m_pend, m_rack, m_busy;
  logic [2:0]  m_cmderr;
  logic [31:0] m_cmd;
  int          m_age;
  logic [6:0]  addrs[9] = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h16, 7'h17, 7'h20, 7'h21, 7'h00};

  function automatic vec_t v(input logic r, w, input logic [6:0] a, input logic [31:0] d,
                             input logic h, ra, ak, input logic [2:0] e, input logic bw,
                             input logic [31:0] bd, er, input logic [5:0] ef, input logic [31:0] ec);
    vec_t t;
    t.req = r; t.wr = w; t.addr = a; t.wdata = d; t.halted = h; t.rack = ra; t.ack = ak;
    t.err = e; t.we = bw; t.wb = bd; t.exp_rdata = er; t.exp_flags = ef; t.exp_cmd = ec;
    return t;
  endfunction

  task automatic drive(input logic r, w, input logic [6:0] a, input logic [31:0] d,
                       input logic h, ra, ak, input logic [2:0] e, input logic bw, input logic [31:0] bd);
    req = r; wr = w; addr = a; wdata = d; halted = h; rack = ra; ack = ak; err = e; we = bw; wb = bd;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a, input logic h);
    case (a)
      7'h04:   return m_data[0];
      7'h05:   return m_data[1];
      7'h10:   return {m_halt, 29'd0, m_ndm, m_act};
      7'h11:   return (m_rack ? 32'h3_0000 : 32'h0) + (h ? 32'h300 : 32'hC00) + 32'h80 + 32'd2;
      7'h16:   return (m_busy ? 32'h1000 : 32'h0) + (32'(m_cmderr) << 8) + 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input logic w, input logic [6:0] a, input logic [31:0] d,
                                     input logic h, ra, ak, input logic [2:0] e, input logic bw,
                                     input logic [31:0] bd);
    logic was_busy;
    was_busy = m_busy;
    if (w && a == 7'h10 && !d[0]) begin
      m_data[0] = 0; m_data[1] = 0; m_halt = 0; m_ndm = 0; m_act = 0; m_pend = 0;
      m_rack = 0; m_busy = 0; m_cmderr = 0; m_cmd = 0; m_age = 0;
      return;
    end
    if (!m_act) begin
      m_act = w && a == 7'h10;
      return;
    end
    if (w && (a == 7'h04 || a == 7'h05)) begin
      if (was_busy) begin
        if (m_cmderr == 0) m_cmderr = 1;
      end else m_data[a[0]] = d;
    end
    if (w && a == 7'h17) begin
      if (was_busy) begin
        if (m_cmderr == 0) m_cmderr = 1;
      end else if (m_cmderr == 0) begin
        if (h) begin m_busy = 1; m_age = 0; m_cmd = d; end
        else m_cmderr = 4;
      end
    end
    if (w && a == 7'h16) m_cmderr = m_cmderr & ~d[10:8];
    if (w && a == 7'h10) begin m_halt = d[31]; m_ndm = d[1]; end
    if (was_busy && bw) m_data[0] = bd;
    if (ra) begin m_pend = 0; m_rack = 1; end
    if (w && a == 7'h10 && d[30] && !d[31]) begin m_pend = 1; m_rack = 0; end
    if (was_busy) begin
      if (ak) begin
        m_busy = 0;
        if (e != 0) m_cmderr = e;
      end else m_age++;
    end
  endfunction

  initial begin
    vec_t tbl[$];
    // flags = {haltreq, resumereq, cmd_req, ndmreset, dmactive, resp}, sampled before the edge
    tbl.push_back(v(1,0,7'h11,32'h0,        0,0,0,0,0,32'h0,        32'h0000_0C82,6'b000001,32'h0));
    tbl.push_back(v(1,1,7'h10,32'h1,        0,0,0,0,0,32'h0,        32'h0,        6'b000001,32'h0));
    tbl.push_back(v(1,1,7'h10,32'h8000_0001,0,0,0,0,0,32'h0,        32'h1,        6'b000011,32'h0));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b100010,32'h0));
    tbl.push_back(v(1,0,7'h11,32'h0,        1,0,0,0,0,32'h0,        32'h0000_0382,6'b100011,32'h0));
    tbl.push_back(v(1,1,7'h17,32'h0022_1000,1,0,0,0,0,32'h0,        32'h0,        6'b100011,32'h0));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,1,32'hDEAD_BEEF,32'h0,        6'b101010,32'h0022_1000));
    tbl.push_back(v(1,0,7'h16,32'h0,        1,0,0,0,0,32'h0,        32'h0000_1002,6'b101011,32'h0022_1000));
    tbl.push_back(v(1,1,7'h17,32'h1234_5678,1,0,0,0,0,32'h0,        32'h0,        6'b101011,32'h0022_1000));
    tbl.push_back(v(1,0,7'h16,32'h0,        1,0,1,0,0,32'h0,        32'h0000_1102,6'b101011,32'h0022_1000));
    tbl.push_back(v(1,0,7'h04,32'h0,        1,0,0,0,0,32'h0,        32'hDEAD_BEEF,6'b100011,32'h0022_1000));
    tbl.push_back(v(1,1,7'h17,32'h00AA_0000,1,0,0,0,0,32'h0,        32'h0,        6'b100011,32'h0022_1000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b100010,32'h0022_1000));
    tbl.push_back(v(1,1,7'h16,32'h700,      1,0,0,0,0,32'h0,        32'h0000_0102,6'b100011,32'h0022_1000));
    tbl.push_back(v(1,0,7'h16,32'h0,        1,0,0,0,0,32'h0,        32'h0000_0002,6'b100011,32'h0022_1000));
    tbl.push_back(v(1,1,7'h10,32'h1,        0,0,0,0,0,32'h0,        32'h8000_0001,6'b100011,32'h0022_1000));
    tbl.push_back(v(1,1,7'h17,32'h1,        0,0,0,0,0,32'h0,        32'h0,        6'b000011,32'h0022_1000));
    tbl.push_back(v(1,0,7'h16,32'h0,        0,0,0,0,0,32'h0,        32'h0000_0402,6'b000011,32'h0022_1000));
    tbl.push_back(v(1,1,7'h16,32'h700,      0,0,0,0,0,32'h0,        32'h0000_0402,6'b000011,32'h0022_1000));
    tbl.push_back(v(1,1,7'h17,32'h0033_0000,1,0,0,0,0,32'h0,        32'h0,        6'b000011,32'h0022_1000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b001010,32'h0033_0000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,1,3,0,32'h0,        32'h0,        6'b001010,32'h0033_0000));
    tbl.push_back(v(1,0,7'h16,32'h0,        1,0,0,0,0,32'h0,        32'h0000_0302,6'b000011,32'h0033_0000));
    tbl.push_back(v(1,1,7'h16,32'h700,      1,0,0,0,0,32'h0,        32'h0000_0302,6'b000011,32'h0033_0000));
    tbl.push_back(v(1,1,7'h10,32'h4000_0001,1,0,0,0,0,32'h0,        32'h1,        6'b000011,32'h0033_0000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b010010,32'h0033_0000));
    tbl.push_back(v(1,0,7'h10,32'h0,        1,0,0,0,0,32'h0,        32'h1,        6'b010011,32'h0033_0000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,1,0,0,0,32'h0,        32'h0,        6'b010010,32'h0033_0000));
    tbl.push_back(v(1,0,7'h11,32'h0,        1,0,0,0,0,32'h0,        32'h0003_0382,6'b000011,32'h0033_0000));
    tbl.push_back(v(1,1,7'h17,32'h1,        1,0,0,0,0,32'h0,        32'h0,        6'b000011,32'h0033_0000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b001010,32'h1));
    tbl.push_back(v(1,1,7'h17,32'h2,        1,0,0,0,0,32'h0,        32'h0,        6'b001011,32'h1));
    tbl.push_back(v(1,1,7'h16,32'h700,      1,0,1,2,0,32'h0,        32'h0000_1102,6'b001011,32'h1));
    tbl.push_back(v(1,0,7'h16,32'h0,        1,0,0,0,0,32'h0,        32'h0000_0202,6'b000011,32'h1));
    tbl.push_back(v(1,1,7'h16,32'h700,      1,0,0,0,0,32'h0,        32'h0000_0202,6'b000011,32'h1));
    tbl.push_back(v(1,1,7'h17,32'h0044_0000,1,0,0,0,0,32'h0,        32'h0,        6'b000011,32'h1));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,0,0,1,32'hCAFE_F00D,32'h0,        6'b001010,32'h0044_0000));
    tbl.push_back(v(1,1,7'h10,32'h0,        1,0,0,0,0,32'h0,        32'h1,        6'b001011,32'h0044_0000));
    tbl.push_back(v(0,0,7'h00,32'h0,        1,0,1,5,0,32'h0,        32'h0,        6'b000000,32'h0));
    tbl.push_back(v(1,0,7'h04,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b000001,32'h0));
    tbl.push_back(v(1,0,7'h16,32'h0,        1,0,0,0,0,32'h0,        32'h0000_0002,6'b000001,32'h0));
    tbl.push_back(v(1,0,7'h11,32'h0,        1,0,0,0,0,32'h0,        32'h0000_0382,6'b000001,32'h0));
    tbl.push_back(v(1,0,7'h20,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b000001,32'h0));
    tbl.push_back(v(1,1,7'h05,32'h1234_5678,1,0,0,0,0,32'h0,        32'h0,        6'b000001,32'h0));
    tbl.push_back(v(1,0,7'h05,32'h0,        1,0,0,0,0,32'h0,        32'h0,        6'b000001,32'h0));

    repeat (2) @(negedge clk);
    #1 check("reset outputs", {haltreq, resumereq, cmd_req, ndmreset, dmactive, resp, rdata, cmd}, '0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].halted, tbl[i].rack,
            tbl[i].ack, tbl[i].err, tbl[i].we, tbl[i].wb);
      #1;
      check($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("vec%0d flags", i), {haltreq, resumereq, cmd_req, ndmreset, dmactive, resp}, tbl[i].exp_flags);
      check($sformatf("vec%0d cmd", i), cmd, tbl[i].exp_cmd);
    end

    // the table leaves the DM inactive, i.e. every register at zero
    m_data[0] = 0; m_data[1] = 0; m_halt = 0; m_ndm = 0; m_act = 0; m_pend = 0;
    m_rack = 0; m_busy = 0; m_cmderr = 0; m_cmd = 0; m_age = 0;

    for (int n = 0; n < 3000; n++) begin
      logic        r, w, h, ra, ak, bw;
      logic [6:0]  a;
      logic [31:0] d, bd;
      logic [2:0]  e;
      int          k;
      @(negedge clk);
      r  = 1'($urandom_range(1));
      w  = 1'($urandom_range(1));
      k  = $urandom_range(8);
      a  = (k == 8) ? 7'($urandom_range(127)) : addrs[k];
      d  = $urandom;
      if (a == 7'h10) begin
        d[0] = $urandom_range(9) != 0;
        if ($urandom_range(2) == 0) d[31:30] = 2'b01;
      end
      h  = (n % 8 == 0) ? 1'($urandom_range(1)) : halted;
      ra = $urandom_range(7) == 0;
      ak = m_busy && m_age >= 1 && $urandom_range(2) == 0;
      e  = $urandom_range(1) ? 3'd0 : 3'($urandom_range(7));
      bw = $urandom_range(3) == 0;
      bd = $urandom;
      drive(r, w, a, d, h, ra, ak, e, bw, bd);
      #1;
      check($sformatf("rand%0d addr=%h", n, a),
            {resp, rdata, haltreq, resumereq, cmd_req, ndmreset, dmactive, cmd},
            {r, r ? model_read(a, h) : 32'h0, m_halt, m_pend, m_busy, m_ndm, m_act, m_cmd});
      model_step(r & w, a, d, h, ra, ak, e, bw, bd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/scr1_dm_dmi_target.md
Name: scr1_dm_dmi_target

Overview:
DMI responder at the Debug Module end of the DMI bus. It accepts single-cycle DMI requests from the DTM side and returns read data in the same cycle. It holds the DM register subset: data0/1, dmcontrol, dmstatus, abstractcs and command. It drives halt/resume requests and an abstract-command handshake toward the hart debug logic.

Parameters:
DATA_W, 32, DMI data width (= SCR1_DBG_DMI_DATA_WIDTH)
ADDR_W, 7, DMI address width (= SCR1_DBG_DMI_ADDR_WIDTH)
DM_VERSION, 4'd2, dmstatus.version value

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
dmi2dm_req_i  in  1  request strobe, one cycle per access
dmi2dm_wr_i  in  1  1=write, 0=read
dmi2dm_addr_i  in  ADDR_W  register address
dmi2dm_wdata_i  in  DATA_W  write data
dm2dmi_resp_o  out  1  response, same cycle as req
dm2dmi_rdata_o  out  DATA_W  read data, same cycle as req
dm2hart_haltreq_o  out  1  level halt request
dm2hart_resumereq_o  out  1  resume pending
hart2dm_resumeack_i  in  1  resume acknowledged (pulse)
hart2dm_halted_i  in  1  hart halted status
dm2hart_cmd_req_o  out  1  abstract command request
dm2hart_cmd_o  out  DATA_W  latched command word
hart2dm_cmd_ack_i  in  1  command done (pulse)
hart2dm_cmd_err_i  in  3  cmderr code, valid with ack
hart2dm_data0_we_i  in  1  hart write-back strobe for data0
hart2dm_data0_i  in  DATA_W  write-back data
dm_ndmreset_o  out  1  non-debug-module reset
dm_dmactive_o  out  1  dmcontrol.dmactive

Behaviour:
- Reset: every output and register is 0; FSM is IDLE.
- Response and read data:
  - dm2dmi_resp_o = dmi2dm_req_i, combinational.
  - rdata is the pre-write register value when req=1, else 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Address map: data0 0x04, data1 0x05, dmcontrol 0x10, dmstatus 0x11 (RO), abstractcs 0x16, command 0x17 (WO, reads 0).
- dmcontrol:
  - Fields: [31] haltreq RW, [30] resumereq W1, [1] ndmreset RW, [0] dmactive RW.
  - Writing resumereq=1 while haltreq=0 sets resume_pend and clears resumeack.
  - resume_pend clears on hart2dm_resumeack_i, which also sets resumeack.
- dmactive=0 synchronously holds all DM state except dmactive at reset values:
  - this includes the FSM: cmd_req_o drops the next cycle; a late ack is ignored.
  - Writes to other registers are ignored while dmactive=0.
- dmstatus bits:
  - [17:16] all/anyresumeack = resumeack
  - [11:10] all/anyrunning = ~halted
  - [9:8] all/anyhalted = halted
  - [7] authenticated = 1
  - [3:0] = DM_VERSION
  - all other bits 0
- abstractcs bits:
  - [28:24] progbufsize
  - [12] busy = (state != IDLE)
  - [10:8] cmderr, W1C
  - [3:0] datacount = 2
- Command acceptance:
  - Write to command while busy, or to data0/1 while busy: write ignored; cmderr := 1 if cmderr == 0.
  - Command write with cmderr != 0: ignored.
  - Command write with hart not halted: cmderr := 4.
  - Otherwise latch wdata into dm2hart_cmd_o and go IDLE -> REQ next cycle.
- FSM:
  - REQ: cmd_req_o=1, held until hart2dm_cmd_ack_i.
  - On ack -> IDLE; if err_i != 0, cmderr := err_i.
  - The ack may arrive one cycle after entering REQ at the earliest.
- Simultaneous events:
  - Error ack in the same cycle as a cmderr W1C write: the new error wins.
- data0 write-back:
  - hart2dm_data0_we_i loads data0 only while busy; it is ignored when IDLE.

Optional Feature:
SCR1_DMI_TARGET_PROGBUF_EN
- With the macro:
  - progbuf0/1 RW at 0x20/0x21.
  - Exported as dm2hart_progbuf0_o/dm2hart_progbuf1_o (DATA_W, reset 0).
  - abstractcs.progbufsize = 2.
  - Writes while busy follow the busy-error rule.
- Without the macro: those addresses are unmapped, the ports are absent, and progbufsize = 0.

Decomposition:
- Package scr1_dm_pkg holds:
  - DM register address enum
  - abstract FSM state enum (IDLE, REQ)
  - cmderr enum (NONE=0, BUSY=1, NOTSUP=2, EXC=3, HALTRESUME=4)
  - dmstatus/abstractcs field-position localparams
- One sub-module, scr1_dm_abs_cmd_fsm, contains the command latch, busy, cmderr and handshake.

Test Plan:
1. Read 0x11 after reset with halted=0 -> resp=1 same cycle; rdata=32'h0000_0C82.
2. Write 0x10 = 32'h8000_0001, drive halted=1, then write 0x17 = 32'h0022_1000 -> cmd_req_o=1 with cmd_o=32'h0022_1000. Write-back data0=32'hDEAD_BEEF, then ack with err=0 -> busy=0; read 0x04 returns 32'hDEAD_BEEF.
3. Write command while busy -> cmderr=1. A later command write is ignored and no new cmd_req. Write 0x16 = 32'h0000_0700 -> cmderr=0.
4. Command with halted=0 -> cmderr=4, no cmd_req. Ack with err=3 on a valid command -> cmderr=3.
5. resumereq: write 0x10 = 32'h4000_0001 -> resumereq_o=1 until resumeack pulse; then dmstatus[17:16]=2'b11.
6. Clear dmactive (write 0x10 = 0) during REQ -> cmd_req_o=0 next cycle, data0 reads 0, and a late ack is ignored.
